// File: rtl/vector_lane_addr_scheduler.sv
// Serialises masked per-lane vector accesses onto one scalar memory port.
// SEW strobes, store replication, load extraction and held fault reporting.
package vector_lane_addr_scheduler_pkg;
  typedef enum logic [1:0] {
    SEW8  = 2'b00,
    SEW16 = 2'b01,
    SEW32 = 2'b10,
    SEWX  = 2'b11
  } sew_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    EXC
  } state_t;
endpackage

module vector_lane_addr_scheduler
  import vector_lane_addr_scheduler_pkg::*;
#(
  parameter int NLANES = 2,
  parameter int LIDX_W = $clog2(NLANES)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NLANES*32-1:0]  addr,
  input  logic [NLANES*32-1:0]  storedata,
  input  logic [NLANES-1:0]     lane_mask,
  input  logic                  load,
  input  logic                  store,
  input  sew_t                  sew,
  input  logic                  dhit,
  input  logic [31:0]           dmem_rdata,
  input  logic                  returnex,
  output logic [31:0]           final_addr,
  output logic [31:0]           final_storedata,
  output logic [3:0]            byte_ena,
  output logic                  ren,
  output logic                  wen,
  output logic [NLANES-1:0]     arrived,
  output logic [NLANES*32-1:0]  loaddata,
  output logic                  done,
  output logic                  exception,
  output logic [LIDX_W-1:0]     exc_lane,
  output logic                  busy
);

  state_t               state, state_n;
  logic [LIDX_W-1:0]    idx, idx_n;
  logic [NLANES*32-1:0] addr_q, data_q;
  logic [NLANES-1:0]    mask_q;
  sew_t                 sew_q;
  logic                 st_q;
  logic [LIDX_W-1:0]    exc_q;

  logic                 latch, exc_ld, ld_we;
  logic [31:0]          cur_addr, cur_data, ld_word;
  logic [3:0]           be;
  logic                 fault;
  logic                 nxt_valid;
  logic [LIDX_W-1:0]    nxt_idx, first_idx;

  assign cur_addr = addr_q[32*idx +: 32];
  assign cur_data = data_q[32*idx +: 32];

  assign fault = (sew_q == SEWX)
              || (sew_q == SEW16 && cur_addr[0])
              || (sew_q == SEW32 && cur_addr[1:0] != 2'b00);

  // Descending scan leaves the lowest qualifying lane.
  always_comb begin
    nxt_valid = 1'b0;
    nxt_idx   = '0;
    first_idx = '0;
    for (int i = NLANES - 1; i >= 0; i--) begin
      if (mask_q[i] && i > int'(idx)) begin
        nxt_valid = 1'b1;
        nxt_idx   = LIDX_W'(i);
      end
      if (lane_mask[i])
        first_idx = LIDX_W'(i);
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    ren     = 1'b0;
    wen     = 1'b0;
    arrived = '0;
    latch   = 1'b0;
    exc_ld  = 1'b0;
    ld_we   = 1'b0;
    unique case (state)
      IDLE: begin
        if (load || store) begin
          latch   = 1'b1;
          idx_n   = first_idx;
          state_n = |lane_mask ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        if (returnex) begin
          state_n = IDLE;
        end else if (fault) begin
          exc_ld  = 1'b1;
          state_n = EXC;
        end else begin
          ren = ~st_q;
          wen = st_q;
          if (dhit) begin
            arrived[idx] = 1'b1;
            ld_we        = ~st_q;
            if (nxt_valid)
              idx_n = nxt_idx;
            else
              state_n = DONE;
          end
        end
      end
      DONE: state_n = IDLE;
      EXC: begin
        if (returnex)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    be              = 4'b1111;
    final_storedata = cur_data;
    ld_word         = dmem_rdata;
    unique case (sew_q)
      SEW8: begin
        be              = 4'b0001 << cur_addr[1:0];
        final_storedata = {4{cur_data[7:0]}};
        ld_word         = {24'h0, dmem_rdata[{cur_addr[1:0], 3'b000} +: 8]};
      end
      SEW16: begin
        be              = 4'b0011 << {cur_addr[1], 1'b0};
        final_storedata = {2{cur_data[15:0]}};
        ld_word         = cur_addr[1] ? {16'h0, dmem_rdata[31:16]}
                                      : {16'h0, dmem_rdata[15:0]};
      end
      default: ;
    endcase
  end

  assign final_addr = cur_addr;
  assign byte_ena   = (ren || wen) ? be : 4'b0000;
  assign done       = (state == DONE);
  assign exception  = (state == EXC);
  assign exc_lane   = exc_q;
  assign busy       = (state != IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      idx      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      sew_q    <= SEW8;
      st_q     <= 1'b0;
      exc_q    <= '0;
      loaddata <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (latch) begin
        addr_q <= addr;
        data_q <= storedata;
        mask_q <= lane_mask;
        sew_q  <= sew;
        st_q   <= store;
      end
      if (exc_ld)
        exc_q <= idx;
      else if (state == EXC && returnex)
        exc_q <= '0;
      if (ld_we)
        loaddata[32*idx +: 32] <= ld_word;
    end
  end

endmodule

// File: tb/tb_vector_lane_addr_scheduler.sv
// Directed bench for vector_lane_addr_scheduler with four lanes.
// Expected values are hand-computed constants per scenario.
module tb_vector_lane_addr_scheduler;
  import vector_lane_addr_scheduler_pkg::*;

  localparam int NL = 4;
  localparam int LW = 2;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [NL*32-1:0] addr, storedata;
  logic [NL-1:0]   lane_mask;
  logic            load, store, dhit, returnex;
  sew_t            sew;
  logic [31:0]     dmem_rdata;
  logic [31:0]     final_addr, final_storedata;
  logic [3:0]      byte_ena;
  logic            ren, wen, done, exception, busy;
  logic [NL-1:0]   arrived;
  logic [NL*32-1:0] loaddata;
  logic [LW-1:0]   exc_lane;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  vector_lane_addr_scheduler #(.NLANES(NL)) dut (
    .CLK(CLK), .nRST(nRST), .addr(addr), .storedata(storedata),
    .lane_mask(lane_mask), .load(load), .store(store), .sew(sew),
    .dhit(dhit), .dmem_rdata(dmem_rdata), .returnex(returnex),
    .final_addr(final_addr), .final_storedata(final_storedata),
    .byte_ena(byte_ena), .ren(ren), .wen(wen), .arrived(arrived),
    .loaddata(loaddata), .done(done), .exception(exception),
    .exc_lane(exc_lane), .busy(busy)
  );

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    nRST = 1'b0; load = 1'b0; store = 1'b0; dhit = 1'b0;
    returnex = 1'b0; sew = SEW8; lane_mask = '0;
    addr = '0; storedata = '0; dmem_rdata = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ren", ren, 0);
    check("rst_wen", wen, 0);
    check("rst_done", done, 0);
    check("rst_exc", exception, 0);
    check("rst_ld", loaddata, 0);
    check("rst_be", byte_ena, 0);
    check("rst_fa", final_addr, 0);
    tick();
    nRST = 1'b1;

    // four-lane 32b load, dhit every cycle
    addr = {32'h10C, 32'h108, 32'h104, 32'h100};
    lane_mask = 4'b1111; sew = SEW32; load = 1'b1; dhit = 1'b1;
    #1 check("t1_idle", busy, 0);
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dmem_rdata = 32'hA000_0001 + i;
      #1;
      check("t1_ren", ren, 1);
      check("t1_fa", final_addr, 32'h100 + 4 * i);
      check("t1_arr", arrived, 4'b0001 << i);
      check("t1_be", byte_ena, 4'b1111);
      tick();
    end
    #1;
    check("t1_done", done, 1);
    check("t1_ren_off", ren, 0);
    check("t1_busy", busy, 1);
    tick();
    check("t1_done_off", done, 0);
    check("t1_idle2", busy, 0);
    check("t1_ld", loaddata,
          {32'hA000_0004, 32'hA000_0003, 32'hA000_0002, 32'hA000_0001});

    // 8b store on lanes 1 and 3
    addr = {32'h200, 32'h0, 32'h203, 32'h0};
    storedata = {32'h0000_00CD, 32'hFFFF_FFFF, 32'h0000_00AB, 32'hFFFF_FFFF};
    lane_mask = 4'b1010; sew = SEW8; store = 1'b1;
    tick();
    store = 1'b0;
    #1;
    check("t2_wen1", wen, 1);
    check("t2_ren1", ren, 0);
    check("t2_be1", byte_ena, 4'b1000);
    check("t2_sd1", final_storedata, 32'hABAB_ABAB);
    check("t2_arr1", arrived, 4'b0010);
    tick();
    check("t2_wen3", wen, 1);
    check("t2_be3", byte_ena, 4'b0001);
    check("t2_sd3", final_storedata, 32'hCDCD_CDCD);
    check("t2_arr3", arrived, 4'b1000);
    tick();
    check("t2_done", done, 1);
    check("t2_wen_off", wen, 0);
    tick();

    // 16b load with three stall cycles
    addr = {32'h0, 32'h0, 32'h0, 32'h102};
    lane_mask = 4'b0001; sew = SEW16; load = 1'b1; dhit = 1'b0;
    dmem_rdata = 32'h1234_ABCD;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_ren_hold", ren, 1);
      check("t3_arr_hold", arrived, 0);
      check("t3_be", byte_ena, 4'b1100);
      tick();
    end
    dhit = 1'b1;
    #1 check("t3_arr", arrived, 4'b0001);
    tick();
    check("t3_done", done, 1);
    tick();
    check("t3_ld", loaddata,
          {32'hA000_0004, 32'hA000_0003, 32'hA000_0002, 32'h0000_1234});

    // misaligned 32b lane 2 after lane 1 completes
    addr = {32'h0, 32'h301, 32'h404, 32'h0};
    lane_mask = 4'b0110; sew = SEW32; load = 1'b1;
    dmem_rdata = 32'hBEEF_0000;
    tick();
    load = 1'b0;
    #1;
    check("t4_ren1", ren, 1);
    check("t4_arr1", arrived, 4'b0010);
    tick();
    check("t4_fault_ren", ren, 0);
    check("t4_fault_arr", arrived, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t4_exc", exception, 1);
      check("t4_lane", exc_lane, 2);
      check("t4_noreq", ren, 0);
      tick();
    end
    check("t4_ld1", loaddata[63:32], 32'hBEEF_0000);
    returnex = 1'b1;
    tick();
    returnex = 1'b0;
    #1;
    check("t4_exc_off", exception, 0);
    check("t4_idle", busy, 0);

    // empty mask
    lane_mask = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    #1;
    check("t5_done", done, 1);
    check("t5_ren", ren, 0);
    tick();
    check("t5_idle", busy, 0);

    // illegal sew
    addr = {32'h0, 32'h0, 32'h0, 32'h100};
    lane_mask = 4'b0001; sew = SEWX; load = 1'b1;
    tick();
    load = 1'b0;
    #1 check("t5_x_ren", ren, 0);
    tick();
    check("t5_x_exc", exception, 1);
    check("t5_x_lane", exc_lane, 0);
    returnex = 1'b1;
    tick();
    returnex = 1'b0;
    #1 check("t5_x_idle", busy, 0);

    // reset during second of four accesses
    addr = {32'h10C, 32'h108, 32'h104, 32'h100};
    lane_mask = 4'b1111; sew = SEW32; load = 1'b1; dhit = 1'b1;
    dmem_rdata = 32'h1111_1111;
    tick();
    load = 1'b0;
    tick();
    nRST = 1'b0;
    #1;
    check("t6_ren", ren, 0);
    check("t6_busy", busy, 0);
    check("t6_arr", arrived, 0);
    check("t6_ld", loaddata, 0);
    check("t6_fa", final_addr, 0);
    tick();
    check("t6_done", done, 0);
    nRST = 1'b1;
    addr = {32'h0, 32'h0, 32'h0, 32'h500};
    lane_mask = 4'b0001; load = 1'b1; dmem_rdata = 32'h0000_0055;
    tick();
    load = 1'b0;
    #1;
    check("t6_ren2", ren, 1);
    check("t6_fa2", final_addr, 32'h500);
    check("t6_arr2", arrived, 4'b0001);
    tick();
    check("t6_done2", done, 1);
    tick();
    check("t6_ld2", loaddata, 128'h55);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
